// File: rtl/display_anim.sv
// display_anim: hex display driver with blank, value, spinner and blink modes.
module display_anim #(
    parameter int TICK_DIV    = 5000000,
    parameter int BLINK_TICKS = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] modo,
    input  logic [3:0] valor,
    input  logic       carrega,
    output logic [4:0] hexa,
    output logic       volta
);
    typedef enum logic [1:0] {APAGADO = 2'b00, VALOR = 2'b01, GIRO = 2'b10, PISCA = 2'b11} state_t;
    state_t state, next;
    logic [23:0] presc;
    logic [7:0] bcnt;
    logic [3:0] valor_reg;
    logic [2:0] pos;
    logic phase, tick, changed, in_giro, in_pisca, blink_wrap;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= APAGADO;
        else state <= next;
    end
    always_comb next = state_t'(modo);
    assign changed    = next != state;
    assign tick       = presc == 24'(TICK_DIV - 1);
    // animations only advance while the mode is held, so a tick on an exit edge is ignored
    assign in_giro    = state == GIRO && !changed;
    assign in_pisca   = state == PISCA && !changed;
    assign blink_wrap = bcnt == 8'(BLINK_TICKS - 1);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor_reg <= '0;
            presc     <= '0;
            pos       <= '0;
            phase     <= 1'b1;
            bcnt      <= '0;
            volta     <= 1'b0;
        end else begin
            if (carrega) valor_reg <= valor;
            presc <= (changed || tick) ? '0 : presc + 24'd1;
            volta <= in_giro && tick && pos == 3'd5;
            if (changed && next == GIRO) pos <= '0;
            else if (in_giro && tick) pos <= (pos == 3'd5) ? 3'd0 : pos + 3'd1;
            if (changed && next == PISCA) begin
                phase <= 1'b1;
                bcnt  <= '0;
            end else if (in_pisca && tick) begin
                bcnt <= blink_wrap ? 8'd0 : bcnt + 8'd1;
                if (blink_wrap) phase <= !phase;
            end
        end
    end
    always_comb
        hexa = state == APAGADO ? 5'h1F :
               state == VALOR   ? {1'b0, valor_reg} :
               state == GIRO    ? 5'h10 + {2'b00, pos} :
               phase            ? {1'b0, valor_reg} : 5'h1F;
endmodule
